// File: rtl/shift_ctrl_pkg.sv
// Shared constants for the shift/rotate controller.
//   WIDTH        datapath width (only 32 is supported)
//   OP_*         operation codes carried on the op input
//   ST_*         FSM state encoding
//   CNT_W        width of the remaining-count register (holds 0..32)
//   op_legal()   true for the five defined op codes
//   eff_count()  effective step count for an accepted request
package shift_ctrl_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_ROL;
    endfunction

    // Rotates wrap, so only the low five bits matter. Shifts saturate at
    // 32 because any larger count gives the same fully-shifted value.
    function automatic logic [CNT_W-1:0] eff_count(input logic [2:0] op,
                                                   input logic [31:0] amount);
        if (op == OP_ROR || op == OP_ROL)
            return {1'b0, amount[4:0]};
        else if (amount >= 32'd32)
            return 6'd32;
        else
            return amount[5:0];
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational step of the shift/rotate datapath.
//   value      current working value
//   op         operation code (legal codes only reach this block)
//   step_size  number of bit positions to move: 1 or 4
//   stepped    value after one step
import shift_ctrl_pkg::*;

module shift_step (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic [2:0]       step_size,
    output logic [WIDTH-1:0] stepped
);

    logic four;
    assign four = (step_size == 3'd4);

    always_comb begin
        stepped = value;
        case (op)
            OP_SHR:  stepped = four ? {4'b0, value[WIDTH-1:4]}
                                    : {1'b0, value[WIDTH-1:1]};
            OP_SHRA: stepped = four ? {{4{value[WIDTH-1]}}, value[WIDTH-1:4]}
                                    : {value[WIDTH-1], value[WIDTH-1:1]};
            OP_SHL:  stepped = four ? {value[WIDTH-5:0], 4'b0}
                                    : {value[WIDTH-2:0], 1'b0};
            OP_ROR:  stepped = four ? {value[3:0], value[WIDTH-1:4]}
                                    : {value[0], value[WIDTH-1:1]};
            OP_ROL:  stepped = four ? {value[WIDTH-5:0], value[WIDTH-1:WIDTH-4]}
                                    : {value[WIDTH-2:0], value[WIDTH-1]};
            default: stepped = value;
        endcase
    end

endmodule

// File: rtl/shift_rot_ctrl.sv
// Multi-cycle shift/rotate controller (IDLE -> RUN -> DONE).
// A request is accepted in IDLE; the working register is then stepped once
// per RUN cycle until the effective count is used up, and done pulses for
// the single DONE cycle with result already valid.
// Optional build macro SHIFT_NIBBLE_STEP_EN: step 4 bits per cycle while at
// least 4 remain, then single bits.
//   clock    rising-edge clock
//   clear_n  asynchronous active-low reset
//   start    request, only sampled in IDLE
//   op       000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL (others illegal)
//   operand  value to transform, latched on accept
//   amount   shift/rotate count, latched on accept
//   busy     high in RUN and DONE
//   done     one-cycle pulse, result valid
//   result   final value, held until the next accepted request completes
//   err      one-cycle pulse after start with an illegal op
module shift_rot_ctrl #(
    parameter int WIDTH = shift_ctrl_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [31:0]      amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);
    import shift_ctrl_pkg::*;

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] eff;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] stepped;
    logic [WIDTH-1:0] result_q;
    logic             err_q;
    logic [2:0]       step_size;

`ifdef SHIFT_NIBBLE_STEP_EN
    assign step_size = (count >= 6'd4) ? 3'd4 : 3'd1;
`else
    assign step_size = 3'd1;
`endif

    assign eff        = eff_count(op, amount);
    assign count_next = count - {3'b000, step_size};

    shift_step u_step (
        .value     (work),
        .op        (op_q),
        .step_size (step_size),
        .stepped   (stepped)
    );

    // result is captured on the edge that enters DONE (it is the final
    // working value), so it is already valid while done is high.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_SHR;
            count    <= '0;
            work     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op_legal(op)) begin
                            op_q  <= op;
                            work  <= operand;
                            count <= eff;
                            if (eff == '0) begin
                                state    <= ST_DONE;
                                result_q <= operand;
                            end else begin
                                state <= ST_RUN;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    work  <= stepped;
                    count <= count_next;
                    if (count_next == '0) begin
                        state    <= ST_DONE;
                        result_q <= stepped;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_shift_rot_ctrl.sv
// Self-checking bench for shift_rot_ctrl: a transaction-level model predicts
// busy/done/result/err every cycle, and directed requests pin exact results
// and latencies. Build with SHIFT_NIBBLE_STEP_EN to check the nibble build.
module tb_shift_rot_ctrl;

    logic        clock   = 1'b0;
    logic        clear_n = 1'b0;
    logic        start   = 1'b0;
    logic [2:0]  op      = 3'b000;
    logic [31:0] operand = '0;
    logic [31:0] amount  = '0;
    logic        busy, done, err;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

`ifdef SHIFT_NIBBLE_STEP_EN
    localparam bit NIB = 1'b1;
`else
    localparam bit NIB = 1'b0;
`endif

    shift_rot_ctrl dut (
        .clock   (clock),
        .clear_n (clear_n),
        .start   (start),
        .op      (op),
        .operand (operand),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] x,
                                                 input logic [31:0] a);
        int unsigned er, es;
        logic [63:0] d;
        logic signed [63:0] s;
        er = a % 32;
        es = (a > 32) ? 32 : a;
        d  = {x, x};
        case (o)
            3'd0: model_result = (es == 32) ? 32'h0 : (x >> es);
            3'd1: begin s = {{32{x[31]}}, x}; s = s >>> es; model_result = s[31:0]; end
            3'd2: model_result = (es == 32) ? 32'h0 : (x << es);
            3'd3: begin d = d >> er; model_result = d[31:0]; end
            default: begin d = d << er; model_result = d[63:32]; end
        endcase
    endfunction

    function automatic int run_cycles(input logic [2:0] o, input logic [31:0] a);
        int unsigned eff;
        eff = (o >= 3'd3) ? (a % 32) : ((a > 32) ? 32 : a);
        if (NIB) return int'(eff / 4 + eff % 4);
        return int'(eff);
    endfunction

    function automatic int lat(input int dflt, input int nib);
        return NIB ? nib : dflt;
    endfunction

    logic        m_busy = 1'b0;
    logic        m_err  = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend   = '0;

    // m_cnt = edges still to go before the done cycle
    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            m_busy = 1'b0; m_err = 1'b0; m_cnt = 0; m_result = '0; m_pend = '0;
        end else begin
            m_err = !m_busy && start && (op > 3'd4);
            if (m_busy) begin
                if (m_cnt == 0) m_busy = 1'b0;
                else begin
                    m_cnt--;
                    if (m_cnt == 0) m_result = m_pend;
                end
            end else if (start && op <= 3'd4) begin
                m_busy = 1'b1;
                m_pend = model_result(op, operand, amount);
                m_cnt  = run_cycles(op, amount);
                if (m_cnt == 0) m_result = m_pend;
            end
        end
    end

    logic chk_en = 1'b0;
    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc busy",   {31'b0, busy}, {31'b0, m_busy});
            chk("cyc done",   {31'b0, done}, {31'b0, m_busy && m_cnt == 0});
            chk("cyc result", result, m_result);
            chk("cyc err",    {31'b0, err},  {31'b0, m_err});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] a, input logic [31:0] exp_res,
                          input int exp_edges, input bit glitch);
        int edges;
        @(negedge clock); #1;
        start = 1'b1; op = o; operand = x; amount = a;
        @(posedge clock); edges = 1; #1;
        start = 1'b0; op = 3'b010; operand = ~x; amount = a + 7;
        while (!done && edges < 200) begin
            if (glitch && edges == 3) begin
                start = 1'b1; operand = 32'hFFFF_FFFF; amount = 1;
            end else start = 1'b0;
            @(posedge clock); edges++; #1;
        end
        start = 1'b0;
        chk({name, " done"},   {31'b0, done}, 32'd1);
        chk({name, " busy"},   {31'b0, busy}, 32'd1);
        chk({name, " edges"},  edges, exp_edges);
        chk({name, " result"}, result, exp_res);
        @(posedge clock); #1;
        chk({name, " idle"},   {31'b0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] prev;
        #1;
        chk("reset busy",   {31'b0, busy}, 32'd0);
        chk("reset done",   {31'b0, done}, 32'd0);
        chk("reset err",    {31'b0, err},  32'd0);
        chk("reset result", result, 32'd0);
        repeat (2) @(negedge clock);
        #1 clear_n = 1'b1;
        chk_en = 1'b1;

        run_op("ror4",     3'd3, 32'h8000_0001, 32'd4,  32'h1800_0000, lat(5, 2),   1'b0);
        run_op("shra40",   3'd1, 32'h8000_0000, 32'd40, 32'hFFFF_FFFF, lat(33, 9),  1'b1);
        run_op("shr40",    3'd0, 32'h8000_0000, 32'd40, 32'h0000_0000, lat(33, 9),  1'b0);
        run_op("rol0",     3'd4, 32'h1234_5678, 32'd0,  32'h1234_5678, 1,           1'b0);
        run_op("ror36",    3'd3, 32'h8000_0001, 32'd36, 32'h1800_0000, lat(5, 2),   1'b0);
        run_op("shl32",    3'd2, 32'hF000_0001, 32'd32, 32'h0000_0000, lat(33, 9),  1'b0);
        run_op("shra32p",  3'd1, 32'h7FFF_FFFF, 32'd32, 32'h0000_0000, lat(33, 9),  1'b0);
        run_op("shr31",    3'd0, 32'hF000_0000, 32'd31, 32'h0000_0001, lat(32, 11), 1'b0);
        run_op("shra4",    3'd1, 32'h8000_0000, 32'd4,  32'hF800_0000, lat(5, 2),   1'b0);
        run_op("rol33",    3'd4, 32'h8000_0000, 32'd33, 32'h0000_0001, 2,           1'b0);
        run_op("rol9",     3'd4, 32'h0000_0001, 32'd9,  32'h0000_0200, lat(10, 4),  1'b0);

        // illegal op: err pulse only
        prev = result;
        @(negedge clock); #1;
        start = 1'b1; op = 3'b111; operand = 32'h0000_0123; amount = 32'd1;
        @(posedge clock); #1;
        start = 1'b0; op = 3'b000;
        chk("illegal err",    {31'b0, err},  32'd1);
        chk("illegal busy",   {31'b0, busy}, 32'd0);
        chk("illegal result", result, prev);
        @(posedge clock); #1;
        chk("illegal err off", {31'b0, err},  32'd0);
        chk("illegal no done", {31'b0, done}, 32'd0);

        // reset abort mid-run
        @(negedge clock); #1;
        start = 1'b1; op = 3'd2; operand = 32'h1; amount = NIB ? 32'd31 : 32'd20;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #1 chk("abort busy before", {31'b0, busy}, 32'd1);
        #1 clear_n = 1'b0;
        #1;
        chk("abort busy",   {31'b0, busy}, 32'd0);
        chk("abort done",   {31'b0, done}, 32'd0);
        chk("abort err",    {31'b0, err},  32'd0);
        chk("abort result", result, 32'd0);
        @(negedge clock); #1;
        clear_n = 1'b1;
        run_op("shl3", 3'd2, 32'h0000_0001, 32'd3, 32'h0000_0008, 4, 1'b0);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_rot_ctrl.md
SHIFT_ROT_CTRL -- requirements
Module: shift_rot_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: clear_n  in  1  asynchronous, active-low reset.
REQ-004 Port: start  in  1  request; sampled only in IDLE.
REQ-005 Port: op  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101-111 illegal.
REQ-006 Port: operand  in  32  value to shift or rotate; latched on accept.
REQ-007 Port: amount  in  32  shift/rotate count; latched on accept.
REQ-008 Port: busy  out  1  high in any state other than IDLE.
REQ-009 Port: done  out  1  one-cycle pulse when result is valid.
REQ-010 Port: result  out  32  final value; held until the next accepted start.
REQ-011 Port: err  out  1  one-cycle pulse when start is sampled with an illegal op.

Function
REQ-012 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 with a legal op SHALL latch operand, op and effective count (eff).
- eff=0: next state DONE.
- eff>0: next state RUN.
REQ-014 Effective count SHALL be:
- rotates: amount mod 32.
- shifts: min(amount, 32), unsigned compare over the full 32 bits.
REQ-015 Each RUN cycle SHALL apply a one-bit step to the working register and decrement the remaining count.
- SHR: zero fill.
- SHRA: sign fill.
- SHL: zero fill.
- ROR/ROL: wrap.
- RUN→DONE on the edge where the remaining count reaches 0.
REQ-016 DONE SHALL assert done for exactly one cycle, load result from the working register, then return to IDLE.
REQ-017 Latency: done SHALL be high in the cycle after eff+1 rising edges, counted from the edge that samples start.
REQ-018 start while busy (RUN or DONE) SHALL be ignored; no queuing.
REQ-019 Illegal op with start in IDLE:
- err=1 for one cycle.
- state stays IDLE.
- result unchanged; done not asserted.
REQ-020 SHL/SHR by 32 SHALL yield 0; SHRA by 32 SHALL yield 32 copies of operand bit 31.
REQ-021 Input changes after accept SHALL NOT affect an operation in progress.

Reset
REQ-022 clear_n=0 SHALL asynchronously force:
- state IDLE.
- busy=0, done=0, err=0.
- result=0, count=0, working register=0.
REQ-023 Reset during RUN or DONE SHALL abort the operation; no done pulse is produced.
REQ-024 The first start is sampled on the first rising edge after clear_n rises.

Configuration
REQ-025 Macro SHIFT_NIBBLE_STEP_EN:
- defined: each RUN cycle steps 4 bits while remaining ≥4, otherwise 1 bit; RUN lasts floor(eff/4)+(eff mod 4) cycles.
- undefined: 1-bit steps only, per REQ-015/REQ-017.
- done semantics, err, reset and results are identical in both builds.

Structure
REQ-026 Package shift_ctrl_pkg SHALL hold:
- WIDTH constant.
- op code constants.
- FSM state encoding.
REQ-027 Sub-module shift_step (combinational) SHALL hold the per-cycle step: inputs value, op, step size (1 or 4); output stepped value. shift_rot_ctrl holds the FSM, counter and registers.

Verification
REQ-028 ROR, operand=0x80000001, amount=4 → result=0x18000000; done after 5 edges.
REQ-029 SHRA, operand=0x80000000, amount=40 → result=0xFFFFFFFF; done after 33 edges; SHR with the same inputs → 0x00000000.
REQ-030 ROL, operand=0x12345678, amount=0 → result=0x12345678; done after 1 edge, busy high for 1 cycle; ROR by 36 equals ROR by 4.
REQ-031 op=3'b111 with start → err pulse of 1 cycle, busy stays 0, result unchanged; a start pulse during RUN → ignored, original result delivered.
REQ-032 SHL by 20, clear_n dropped after 7 RUN cycles → outputs immediately zero, no done; a subsequent SHL 0x1 by 3 → 0x00000008.
REQ-033 SHIFT_NIBBLE_STEP_EN build: ROL 0x00000001 by 9 → 0x00000200; done after 4 edges (steps 4, 4, 1).
